cpu_uart_tx: RTL and testbench
==============================

Name: cpu_uart_tx

Overview:
- Downstream consumer of the tt_um_cpu output byte stream. Buffers bytes the CPU emits in a small FIFO and serialises them as 8N1 UART frames on a single pin.
- Sits between the CPU core's output port and a uo_out bit. It gives the chip a debug/console channel without stalling the core except when the FIFO is full.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range ≥2.
- FIFO_DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  CPU presents a byte.
- in_data  input  8  byte to transmit.
- in_ready  output  1  FIFO can accept; a byte transfers on any edge with in_valid && in_ready.
- tx  output  1  UART line, idle high, registered.
- busy  output  1  high while a frame is on the line (state != IDLE).
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered, excluding the one being shifted.

Behaviour:
- Reset (rst_n low at an edge):
  - tx=1, busy=0, fifo_count=0, in_ready=1.
  - Read/write pointers=0, FSM=IDLE, baud counter=0.
  - Mid-frame reset aborts the frame: tx=1 from the next edge, and buffered bytes are discarded.
- in_ready:
  - in_ready = (fifo_count < FIFO_DEPTH), derived only from the registered count.
  - A pop in the same cycle does NOT enable a push into a full FIFO.
- FIFO updates:
  - Push writes the byte at the write pointer; pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when enabled).
- IDLE:
  - tx=1.
  - If fifo_count>0 at an edge: pop the head into the shift register, baud counter=0, go to START, and drive tx=0 from that edge.
  - Latency: a byte accepted into an empty idle block at edge N gives tx low from edge N+1.
- Bit timing: each bit is held exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1 and the state or bit advances on the edge where the counter equals CLKS_PER_BIT-1.
- DATA:
  - 8 bits, LSB first.
  - A 3-bit index wraps 7→STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the final edge, if fifo_count>0, pop and go directly to START: no idle gap, tx falls on that edge.
  - Otherwise go to IDLE.
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity).
- busy: registered, 1 in every state except IDLE.
- in_data is sampled only on the accepting edge. Changes on in_data while in_ready=0 have no effect.

Optional Feature:
- Macro: CPU_UART_TX_PARITY_EN.
- Defined: PARITY state between DATA and STOP.
  - Drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 11 bits.
- Undefined: no PARITY state, 8N1 frames, no parity logic synthesised.

Test Plan:
- Single byte, CLKS_PER_BIT=4: push 0xA5 from idle at edge 0.
  - tx falls at edge 1.
  - tx then reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total).
  - busy=1 throughout, then 0 with tx=1.
- Backpressure, FIFO_DEPTH=4: hold in_valid=1 with bytes 0x01..0x06 from idle.
  - 0x01–0x05 are accepted on consecutive edges, since 0x01 pops at edge 1.
  - in_ready drops after the fifth accept and 0x06 stalls until the first frame completes.
  - All bytes are transmitted in order.
- Back-to-back: two bytes buffered, 0x00 then 0xFF.
  - The stop bit of frame 1 lasts exactly CLKS_PER_BIT cycles.
  - The start of frame 2 begins on the next cycle with no extra idle.
  - busy never drops between frames.
- Mid-frame reset: assert rst_n=0 for 1 cycle during bit 3 of a frame with 2 bytes queued.
  - The next edge gives tx=1, busy=0, fifo_count=0, in_ready=1.
  - No further frames are sent.
- Simultaneous push/pop: push a byte on the same edge a STOP completes with fifo_count=2.
  - fifo_count stays 2.
  - The pushed byte is sent after the queued ones.
- Parity build (CPU_UART_TX_PARITY_EN): 0xA5 gives a parity bit of 0 and 0x07 gives 1.
  - Frame length is 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/cpu_uart_tx.sv
// cpu_uart_tx: byte FIFO in front of a UART transmitter that sends 8N1 frames.
// Bytes from the CPU output port are queued and then shifted out LSB first on tx.
// Optional build macro CPU_UART_TX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit, which makes each frame 11 bits long.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line high, waiting for a buffered byte
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first, bit_idx_q selects the bit
// S_PARITY | even parity of the data byte (CPU_UART_TX_PARITY_EN only)
// S_STOP   | stop bit (high); may chain straight into the next START
module cpu_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef CPU_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q, busy_q;
  logic          push, pop, baud_last;

  // in_ready comes only from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready   = (count_q < CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign baud_last  = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign pop        = (count_q != '0) &&
                      ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_last));
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  // Next buffered-byte count; a simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            baud_q  <= '0;
            state_q <= S_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef CPU_UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= ^shift_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`ifdef CPU_UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              // chain into the next frame with no idle gap
              shift_q <= mem_q[rd_ptr_q];
              state_q <= S_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_uart_tx.sv
// Bench for cpu_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4. Works for both the
// default build and the CPU_UART_TX_PARITY_EN build.
module tb_cpu_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef CPU_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, tx, busy;
  logic [2:0] fifo_count;

  cpu_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vt[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line bits in time order (bit 0 = start bit).
  function automatic logic [10:0] line_bits(input logic [7:0] d, input logic p);
`ifdef CPU_UART_TX_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // Present a byte from a negedge; junk on in_data while stalled. acc = accepting edge.
  task automatic send(input logic [7:0] b, input bit track, output int acc);
    int w;
    w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    while (!in_ready && w < 2000) begin
      in_data = 8'($urandom);
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    in_data = b;
    acc = cyc + 1;
    if (track) sb.push_back(b);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic capture(input int n, output logic [127:0] t, output logic [127:0] b);
    t = '0;
    b = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      t[k] = tx;
      b[k] = busy;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int w = 0; w < 3000 && !done; w++) begin
      @(negedge clk);
      if (!busy && fifo_count == 3'd0 && sb.size() == 0) done = 1'b1;
    end
    check("drain_timeout", done, 1);
  endtask

  // Scoreboard monitor: decodes frames at bit centres and pops expected bytes.
  initial begin
    logic [7:0] d, e;
    logic s, p;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        check("mon_start", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = tx;
        end
`ifdef CPU_UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        p = tx;
`else
        p = 1'b0;
`endif
        repeat (CPB) @(negedge clk);
        s = tx;
        if (sb.size() == 0) begin
          check("mon_unexpected_frame", d, 'hx00);
        end else begin
          e = sb.pop_front();
          check("mon_data", d, e);
          check("mon_stop", s, 1);
`ifdef CPU_UART_TX_PARITY_EN
          check("mon_parity", p, ^e);
`endif
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, a[6], t0, lows;
    logic [127:0] t, b, et, eb;
    logic [10:0] lb;

    vt[0] = '{8'hA5, 1'b0};
    vt[1] = '{8'h07, 1'b1};
    vt[2] = '{8'h00, 1'b0};
    vt[3] = '{8'hFF, 1'b0};
    vt[4] = '{8'h3C, 1'b0};
    vt[5] = '{8'h80, 1'b1};
    vt[6] = '{8'h5A, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // single frames, cycle-exact waveform per table record
    foreach (vt[r]) begin
      send(vt[r].data, 1'b1, acc);
      @(negedge clk);
      capture(FRAME + 1, t, b);
      lb = line_bits(vt[r].data, vt[r].par);
      et = '0;
      eb = '0;
      for (int k = 0; k < FRAME; k++) begin
        et[k] = lb[k / CPB];
        eb[k] = 1'b1;
      end
      et[FRAME] = 1'b1;
      eb[FRAME] = 1'b0;
      check($sformatf("frame_tx_%02h", vt[r].data), t, et);
      check($sformatf("frame_busy_%02h", vt[r].data), b, eb);
      wait_idle();
    end

    // backpressure: 0x01..0x06 with in_valid held
    for (int i = 0; i < 5; i++) send(8'(i + 1), 1'b1, a[i]);
    @(negedge clk);
    check("bp_count_full", fifo_count, 4);
    check("bp_ready_low", in_ready, 0);
    send(8'h06, 1'b1, a[5]);
    for (int i = 1; i < 5; i++) check($sformatf("bp_accept_%0d", i + 1), a[i] - a[0], i);
    check("bp_accept_6", a[5] - a[0], FRAME + 2);
    wait_idle();

    // back-to-back frames, no idle gap
    send(8'h00, 1'b1, acc);
    send(8'hFF, 1'b1, acc);
    capture(2 * FRAME + 1, t, b);
    et = '0;
    eb = '0;
    for (int k = 0; k < FRAME; k++) begin
      lb = line_bits(8'h00, 1'b0);
      et[k] = lb[k / CPB];
      lb = line_bits(8'hFF, 1'b0);
      et[k + FRAME] = lb[k / CPB];
      eb[k] = 1'b1;
      eb[k + FRAME] = 1'b1;
    end
    et[2 * FRAME] = 1'b1;
    check("b2b_tx", t, et);
    check("b2b_busy", b, eb);
    wait_idle();

    // simultaneous push/pop on the STOP-completion edge
    send(8'h11, 1'b1, t0);
    send(8'h22, 1'b1, acc);
    send(8'h33, 1'b1, acc);
    for (int w = 0; w < 200 && cyc != t0 + FRAME - 1; w++) @(negedge clk);
    send(8'h44, 1'b1, acc);
    check("pp_accept_edge", acc - t0, FRAME + 1);
    @(negedge clk);
    check("pp_count", fifo_count, 2);
    check("pp_new_start", tx, 0);
    wait_idle();

    // mid-frame reset during data bit 3 with two bytes queued
    mon_en = 1'b0;
    send(8'hC3, 1'b0, t0);
    send(8'h5A, 1'b0, acc);
    send(8'h96, 1'b0, acc);
    for (int w = 0; w < 200 && cyc != t0 + 17; w++) @(negedge clk);
    check("mr_count_before", fifo_count, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mr_tx", tx, 1);
    check("mr_busy", busy, 0);
    check("mr_count", fifo_count, 0);
    check("mr_ready", in_ready, 1);
    lows = 0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      if (tx == 1'b0 || busy) lows++;
    end
    check("mr_no_frames", lows, 0);
    mon_en = 1'b1;

    // one more frame after the reset to confirm recovery
    send(8'h3E, 1'b1, acc);
    wait_idle();
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
